reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 4: maximum outstanding register writes, legal range 1..31.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ID_SB_req_i, input, 1: decode holds a decoded instruction and requests register access.
REQ-005 SHALL have ports ID_SB_rs1_i and ID_SB_rs2_i, input, 5 each: source register indices; 0 means unused or x0.
REQ-006 SHALL have port ID_SB_rd_i, input, 5: destination register index.
REQ-007 SHALL have port ID_SB_rd_valid_i, input, 1: instruction writes rd.
REQ-008 SHALL have port ID_SB_issue_i, input, 1: decode-to-EX hand-off occurs this cycle.
REQ-009 SHALL have port SB_ID_access_o, output, 1: register access granted; drives decode's register-access input.
REQ-010 SHALL have ports WB_SB_write_i (input, 1) and WB_SB_rd_i (input, 5): writeback retires a write to rd.
REQ-011 SHALL have port flush_i, input, 1: pipeline flush that discards all in-flight writes.
REQ-012 SHALL have ports SB_stall_o (output, 1), SB_pending_o (output, 5: outstanding write count) and SB_err_o (output, 1: sticky protocol error).

Function
REQ-013 SHALL hold a 32-bit busy vector; bit 0 SHALL be permanently 0.
REQ-014 SHALL hold a pending counter, 0..MAX_PENDING.
REQ-015 SHALL assert SB_ID_access_o combinationally only when all of these hold:
  - ID_SB_req_i is high and the state is not FLUSH;
  - busy[rs1] and busy[rs2] are 0;
  - if ID_SB_rd_valid_i is high and rd != 0: busy[rd] is 0 (WAW stall) and pending < MAX_PENDING.
REQ-016 SHALL perform an issue when ID_SB_issue_i && SB_ID_access_o; a rd-valid, nonzero-rd issue sets busy[rd] and adds 1 to pending at the next edge.
REQ-017 SHALL ignore ID_SB_issue_i while SB_ID_access_o is low.
REQ-018 SHALL handle WB_SB_write_i with busy[WB_SB_rd_i]=1 and rd != 0 by clearing that bit and subtracting 1 from pending at the next edge.
REQ-019 SHALL treat WB_SB_write_i to a non-busy register or to x0 as follows: no busy or pending change; set SB_err_o if the register is non-busy and nonzero.
REQ-020 SHALL, when issue and WB occur in the same cycle, apply both; pending stays net unchanged; for the same rd, set wins over clear.
REQ-021 SHALL implement an FSM with states READY, STALL and FLUSH.
REQ-022 SHALL make these FSM transitions:
  - READY to STALL: ID_SB_req_i && !SB_ID_access_o.
  - STALL to READY: SB_ID_access_o, or ID_SB_req_i dropped.
  - Any state to FLUSH: flush_i.
  - FLUSH to READY: unconditionally after one cycle.
REQ-023 SHALL drive SB_stall_o high exactly when the state is STALL (registered, one cycle behind the request).
REQ-024 SHALL, on entering FLUSH, clear busy and pending; WB and issue inputs in the flush_i cycle and the FLUSH cycle SHALL be ignored.
REQ-025 SHALL give flush_i priority over all other inputs in the same cycle.
REQ-026 SHALL never let pending wrap; a decrement at 0 is impossible by REQ-019.

Reset
REQ-027 SHALL, on reset_i high at a clock edge, set state=READY, busy=0, pending=0 and SB_err_o=0.
REQ-028 SHALL give reset priority over flush_i; reset mid-operation discards all outstanding writes.
REQ-029 SHALL drive SB_ID_access_o and SB_stall_o low while reset_i is high.

Configuration
REQ-030 SHALL, with SCOREBOARD_WB_BYPASS_EN defined, treat a register cleared by a same-cycle WB (WB_SB_write_i, matching rd) as not busy in REQ-015, and release the WB slot for the pending check.
REQ-031 SHALL, without SCOREBOARD_WB_BYPASS_EN, check the grant against registered busy and pending only (one cycle longer stall).

Structure
REQ-032 SHALL place the FSM state enum, REG_ADDR_W=5 and NUM_REGS=32 in shared package sb_pkg.
REQ-033 SHALL isolate the combinational hazard check (REQ-015 and REQ-030) in sub-module sb_hazard_chk; registers and FSM SHALL stay in reg_scoreboard.

Verification
REQ-034 SHALL cover RAW stall: issue rd=5; next cycle req with rs1=5 gives access=0 and stall=1 the following cycle; WB rd=5 gives access=1 the next cycle (bypass: same cycle).
REQ-035 SHALL cover capacity: with MAX_PENDING=4, issue rd=1..4; a req with rd=6 gives access=0 and pending=4; a req with rd_valid=0, rs1=7 gives access=1.
REQ-036 SHALL cover simultaneous events: issue rd=3 together with WB rd=2 (busy) leaves pending unchanged, busy[3]=1 and busy[2]=0.
REQ-037 SHALL cover x0 and error handling: issue rd=0 leaves pending unchanged; WB rd=9 while not busy sets SB_err_o=1 and leaves it set until reset.
REQ-038 SHALL cover flush: with 3 pending, flush_i plus same-cycle WB rd=1 gives FLUSH, then busy=0, pending=0, READY.
REQ-039 SHALL cover reset: reset_i mid-STALL gives READY, access recomputed, pending=0 and err=0 on the next cycle.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and constants for the register scoreboard.
package sb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } sb_state_e;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback <-> scoreboard handshake bundle; master is the pipeline side.
interface reg_scoreboard_if;
    import sb_pkg::*;

    logic      ID_SB_req_i;
    reg_addr_t ID_SB_rs1_i;
    reg_addr_t ID_SB_rs2_i;
    reg_addr_t ID_SB_rd_i;
    logic      ID_SB_rd_valid_i;
    logic      ID_SB_issue_i;
    logic      SB_ID_access_o;
    logic      WB_SB_write_i;
    reg_addr_t WB_SB_rd_i;

    modport master (
        output ID_SB_req_i, ID_SB_rs1_i, ID_SB_rs2_i, ID_SB_rd_i,
               ID_SB_rd_valid_i, ID_SB_issue_i, WB_SB_write_i, WB_SB_rd_i,
        input  SB_ID_access_o
    );

    modport slave (
        input  ID_SB_req_i, ID_SB_rs1_i, ID_SB_rs2_i, ID_SB_rd_i,
               ID_SB_rd_valid_i, ID_SB_issue_i, WB_SB_write_i, WB_SB_rd_i,
        output SB_ID_access_o
    );
endinterface

// File: rtl/sb_hazard_chk.sv
// Combinational RAW/WAW/capacity grant check, zero latency.
// SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback release its register and slot.
module sb_hazard_chk
    import sb_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic                enable_i,
    input  logic [NUM_REGS-1:0] busy_i,
    input  logic [4:0]          pending_i,
    input  reg_addr_t           rs1_i,
    input  reg_addr_t           rs2_i,
    input  reg_addr_t           rd_i,
    input  logic                rd_valid_i,
`ifdef SCOREBOARD_WB_BYPASS_EN
    input  logic                wb_write_i,
    input  reg_addr_t           wb_rd_i,
`endif
    output logic                access_o
);
    logic [NUM_REGS-1:0] busy_eff;
    logic [5:0]          pend_eff;
    logic                need_rd;

    always_comb begin
        busy_eff = busy_i;
        pend_eff = {1'b0, pending_i};
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_write_i && (wb_rd_i != '0) && busy_i[wb_rd_i]) begin
            busy_eff[wb_rd_i] = 1'b0;
            pend_eff          = pend_eff - 6'd1;
        end
`endif
        need_rd  = rd_valid_i && (rd_i != '0);
        access_o = enable_i && !busy_eff[rs1_i] && !busy_eff[rs2_i] &&
                   (!need_rd || (!busy_eff[rd_i] && (pend_eff < 6'(MAX_PENDING))));
    end
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: busy vector, pending count, READY/STALL/FLUSH FSM.
// Optional SCOREBOARD_WB_BYPASS_EN: writeback clears are visible to the grant in the same cycle.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             flush_i,
    reg_scoreboard_if.slave  sb_if,
    output logic             SB_stall_o,
    output logic [4:0]       SB_pending_o,
    output logic             SB_err_o
);
    sb_state_e           state_q, state_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [4:0]          pending_q, pending_d;
    logic                err_q, err_d;
    logic                access;
    logic                issue_set, wb_clr, wb_bad;

    sb_hazard_chk #(.MAX_PENDING(MAX_PENDING)) u_hazard (
        .enable_i   (sb_if.ID_SB_req_i && (state_q != ST_FLUSH) && !reset_i),
        .busy_i     (busy_q),
        .pending_i  (pending_q),
        .rs1_i      (sb_if.ID_SB_rs1_i),
        .rs2_i      (sb_if.ID_SB_rs2_i),
        .rd_i       (sb_if.ID_SB_rd_i),
        .rd_valid_i (sb_if.ID_SB_rd_valid_i),
`ifdef SCOREBOARD_WB_BYPASS_EN
        .wb_write_i (sb_if.WB_SB_write_i),
        .wb_rd_i    (sb_if.WB_SB_rd_i),
`endif
        .access_o   (access)
    );

    assign sb_if.SB_ID_access_o = access;
    assign SB_stall_o           = (state_q == ST_STALL) && !reset_i;
    assign SB_pending_o         = pending_q;
    assign SB_err_o             = err_q;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        pending_d = pending_q;
        err_d     = err_q;
        issue_set = sb_if.ID_SB_issue_i && access && sb_if.ID_SB_rd_valid_i &&
                    (sb_if.ID_SB_rd_i != '0);
        wb_clr    = sb_if.WB_SB_write_i && (sb_if.WB_SB_rd_i != '0) &&
                    busy_q[sb_if.WB_SB_rd_i];
        wb_bad    = sb_if.WB_SB_write_i && (sb_if.WB_SB_rd_i != '0) &&
                    !busy_q[sb_if.WB_SB_rd_i];

        if (flush_i) begin
            state_d   = ST_FLUSH;
            busy_d    = '0;
            pending_d = '0;
        end else begin
            case (state_q)
                ST_READY: if (sb_if.ID_SB_req_i && !access) state_d = ST_STALL;
                ST_STALL: if (access || !sb_if.ID_SB_req_i) state_d = ST_READY;
                default:  state_d = ST_READY;
            endcase
            // Everything arriving during the FLUSH cycle is dropped.
            if (state_q != ST_FLUSH) begin
                if (wb_clr)    busy_d[sb_if.WB_SB_rd_i] = 1'b0;
                if (issue_set) busy_d[sb_if.ID_SB_rd_i] = 1'b1;
                pending_d = pending_q + {4'd0, issue_set} - {4'd0, wb_clr};
                if (wb_bad) err_d = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= ST_READY;
            busy_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: RAW, capacity, simultaneous events, x0/err, flush, reset.
module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       reset_i;
    logic       flush_i;
    logic       stall;
    logic [4:0] pending;
    logic       err;
    int         checks   = 0;
    int         failures = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    reg_scoreboard_if sb_if ();

    reg_scoreboard #(.MAX_PENDING(4)) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .sb_if        (sb_if),
        .SB_stall_o   (stall),
        .SB_pending_o (pending),
        .SB_err_o     (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        flush_i = 1'b0;
        sb_if.ID_SB_req_i      = 1'b1;
        sb_if.ID_SB_rs1_i      = '0;
        sb_if.ID_SB_rs2_i      = '0;
        sb_if.ID_SB_rd_i       = '0;
        sb_if.ID_SB_rd_valid_i = 1'b0;
        sb_if.ID_SB_issue_i    = 1'b0;
        sb_if.WB_SB_write_i    = 1'b0;
        sb_if.WB_SB_rd_i       = '0;
        tick(); tick();
        #1;
        chk("rst_access",  {31'd0, sb_if.SB_ID_access_o}, 0);
        chk("rst_stall",   {31'd0, stall}, 0);
        chk("rst_pending", {27'd0, pending}, 0);
        chk("rst_err",     {31'd0, err}, 0);
        reset_i = 1'b0;
        #1 chk("idle_access", {31'd0, sb_if.SB_ID_access_o}, 1);

        // RAW stall on rd=5
        sb_if.ID_SB_rd_i = 5'd5; sb_if.ID_SB_rd_valid_i = 1'b1; sb_if.ID_SB_issue_i = 1'b1;
        #1 chk("raw_issue_access", {31'd0, sb_if.SB_ID_access_o}, 1);
        tick();
        sb_if.ID_SB_issue_i = 1'b0; sb_if.ID_SB_rd_valid_i = 1'b0; sb_if.ID_SB_rs1_i = 5'd5;
        #1;
        chk("raw_pending1", {27'd0, pending}, 1);
        chk("raw_access0",  {31'd0, sb_if.SB_ID_access_o}, 0);
        chk("raw_stall_lag", {31'd0, stall}, 0);
        tick();
        chk("raw_stall1",   {31'd0, stall}, 1);
        chk("raw_access0b", {31'd0, sb_if.SB_ID_access_o}, 0);
        sb_if.WB_SB_write_i = 1'b1; sb_if.WB_SB_rd_i = 5'd5;
        #1 chk("raw_wb_cycle_access", {31'd0, sb_if.SB_ID_access_o}, {31'd0, BYP});
        tick();
        sb_if.WB_SB_write_i = 1'b0;
        #1;
        chk("raw_post_wb_access", {31'd0, sb_if.SB_ID_access_o}, 1);
        chk("raw_post_wb_pending", {27'd0, pending}, 0);
        chk("raw_post_wb_stall", {31'd0, stall}, {31'd0, !BYP});
        tick();
        sb_if.ID_SB_rs1_i = '0;
        chk("raw_ready_stall", {31'd0, stall}, 0);

        // Capacity: fill rd=1..4
        for (int i = 1; i <= 4; i++) begin
            sb_if.ID_SB_rd_i = 5'(i); sb_if.ID_SB_rd_valid_i = 1'b1; sb_if.ID_SB_issue_i = 1'b1;
            #1 chk("cap_fill_access", {31'd0, sb_if.SB_ID_access_o}, 1);
            tick();
        end
        sb_if.ID_SB_issue_i = 1'b0; sb_if.ID_SB_rd_i = 5'd6;
        #1;
        chk("cap_pending4", {27'd0, pending}, 4);
        chk("cap_full_access", {31'd0, sb_if.SB_ID_access_o}, 0);
        sb_if.ID_SB_rd_valid_i = 1'b0; sb_if.ID_SB_rs1_i = 5'd7;
        #1 chk("cap_nord_access", {31'd0, sb_if.SB_ID_access_o}, 1);
        tick();

        // Retire rd=3, then issue rd=3 alongside WB rd=2
        sb_if.ID_SB_rs1_i = '0;
        sb_if.WB_SB_write_i = 1'b1; sb_if.WB_SB_rd_i = 5'd3;
        tick();
        sb_if.WB_SB_write_i = 1'b0;
        #1 chk("sim_pending3", {27'd0, pending}, 3);
        sb_if.ID_SB_rd_i = 5'd3; sb_if.ID_SB_rd_valid_i = 1'b1; sb_if.ID_SB_issue_i = 1'b1;
        sb_if.WB_SB_write_i = 1'b1; sb_if.WB_SB_rd_i = 5'd2;
        #1 chk("sim_issue_access", {31'd0, sb_if.SB_ID_access_o}, 1);
        tick();
        sb_if.ID_SB_issue_i = 1'b0; sb_if.WB_SB_write_i = 1'b0; sb_if.ID_SB_rd_valid_i = 1'b0;
        #1 chk("sim_pending_net", {27'd0, pending}, 3);
        sb_if.ID_SB_rs1_i = 5'd3;
        #1 chk("sim_busy3", {31'd0, sb_if.SB_ID_access_o}, 0);
        sb_if.ID_SB_rs1_i = 5'd2;
        #1 chk("sim_free2", {31'd0, sb_if.SB_ID_access_o}, 1);
        sb_if.ID_SB_rs1_i = '0;

        // x0 issue and writeback, then error on non-busy rd=9
        sb_if.ID_SB_rd_i = 5'd0; sb_if.ID_SB_rd_valid_i = 1'b1; sb_if.ID_SB_issue_i = 1'b1;
        #1 chk("x0_issue_access", {31'd0, sb_if.SB_ID_access_o}, 1);
        tick();
        sb_if.ID_SB_issue_i = 1'b0; sb_if.ID_SB_rd_valid_i = 1'b0;
        chk("x0_pending", {27'd0, pending}, 3);
        sb_if.WB_SB_write_i = 1'b1; sb_if.WB_SB_rd_i = 5'd0;
        tick();
        sb_if.WB_SB_write_i = 1'b0;
        chk("x0_wb_err", {31'd0, err}, 0);
        chk("x0_wb_pending", {27'd0, pending}, 3);
        sb_if.WB_SB_write_i = 1'b1; sb_if.WB_SB_rd_i = 5'd9;
        tick();
        sb_if.WB_SB_write_i = 1'b0;
        chk("err_set", {31'd0, err}, 1);
        chk("err_pending", {27'd0, pending}, 3);
        tick(); tick();
        chk("err_sticky", {31'd0, err}, 1);

        // Flush with same-cycle WB rd=1, then WB during FLUSH
        flush_i = 1'b1; sb_if.WB_SB_write_i = 1'b1; sb_if.WB_SB_rd_i = 5'd1; sb_if.ID_SB_rs1_i = 5'd3;
        tick();
        flush_i = 1'b0; sb_if.WB_SB_rd_i = 5'd4;
        #1;
        chk("flush_access", {31'd0, sb_if.SB_ID_access_o}, 0);
        chk("flush_pending", {27'd0, pending}, 0);
        chk("flush_stall", {31'd0, stall}, 0);
        tick();
        sb_if.WB_SB_write_i = 1'b0;
        #1;
        chk("post_flush_pending", {27'd0, pending}, 0);
        chk("post_flush_access", {31'd0, sb_if.SB_ID_access_o}, 1);
        chk("post_flush_err", {31'd0, err}, 1);

        // Reset in the middle of a stall
        sb_if.ID_SB_rs1_i = '0; sb_if.ID_SB_rd_i = 5'd8; sb_if.ID_SB_rd_valid_i = 1'b1; sb_if.ID_SB_issue_i = 1'b1;
        tick();
        sb_if.ID_SB_issue_i = 1'b0; sb_if.ID_SB_rd_valid_i = 1'b0; sb_if.ID_SB_rs1_i = 5'd8;
        #1 chk("rs_access0", {31'd0, sb_if.SB_ID_access_o}, 0);
        tick();
        chk("rs_stall1", {31'd0, stall}, 1);
        reset_i = 1'b1;
        #1;
        chk("rs_hold_access", {31'd0, sb_if.SB_ID_access_o}, 0);
        chk("rs_hold_stall", {31'd0, stall}, 0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("rs_pending", {27'd0, pending}, 0);
        chk("rs_err", {31'd0, err}, 0);
        chk("rs_stall", {31'd0, stall}, 0);
        chk("rs_access", {31'd0, sb_if.SB_ID_access_o}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
